dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single 32-bit data-memory port between the CPU load/store unit and the DMA word engine, which moves one 512-bit cache line as 16 consecutive word accesses. A DMA line transfer is granted as one atomic burst. Otherwise CPU single accesses and DMA bursts alternate round-robin, so neither side starves. The block sits between the CPU, the DMA engine and the data-memory macro. It owns the memory enables and routes read data back to whichever side issued the read.

## Interface
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory word width
- BURST_LEN, 16, DMA beats per line (CL_SIZE_WIDTH / WORD_SIZE)
- MAX_GAP, 8, consecutive idle DMA cycles inside a burst before the burst is aborted
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- cpu_req / cpu_we  in  1 / 1  CPU access request / write
- cpu_addr / cpu_wdata  in  ADDR_WIDTH / DATA_WIDTH  CPU address / write data
- cpu_stall  out  1  CPU request not granted this cycle
- cpu_rdata / cpu_rvalid  out  DATA_WIDTH / 1  CPU read return
- dma_req / dma_we  in  1 / 1  DMA beat request (DMAEn) / write (DMAWrEn)
- dma_addr / dma_wdata  in  ADDR_WIDTH / DATA_WIDTH  DMA address / data
- dma_grant  out  1  DMA beat accepted this cycle
- dma_rdata / dma_rvalid  out  DATA_WIDTH / 1  DMA read return
- dma_busy / dma_abort  out  1 / 1  burst in progress / one-cycle abort pulse
- mem_en / mem_we  out  1 / 1  memory enable / write
- mem_addr / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  memory address / data
- mem_rdata  in  DATA_WIDTH  memory read data, one-cycle latency

## Operation
- States:
  - IDLE: no burst in progress.
  - DMA_BURST: DMA owns the port.
- Registers:
  - beat_cnt, width $clog2(BURST_LEN+1)
  - gap_cnt, width $clog2(MAX_GAP+1)
  - last_owner, CPU or DMA
  - rd_tag, NONE, CPU or DMA
- IDLE arbitration, combinational:
  - dma_req and (!cpu_req or last_owner==CPU): grant DMA, go to DMA_BURST, beat_cnt←1.
  - Else if cpu_req: grant CPU, last_owner←CPU.
- DMA_BURST:
  - dma_req high: grant DMA, beat_cnt++, gap_cnt←0.
  - dma_req low: gap_cnt++. The CPU stays stalled, because the burst is locked.
  - After beat BURST_LEN is granted: go to IDLE, last_owner←DMA, beat_cnt←0.
  - gap_cnt reaches MAX_GAP: go to IDLE, pulse dma_abort for 1 cycle, last_owner←DMA, counters←0.
- Memory port:
  - mem_* is a combinational mux of the granted requester.
  - mem_en is high only when there is a grant.
- Read routing:
  - A granted read (mem_we=0) sets rd_tag to the owner; otherwise rd_tag←NONE.
  - Next cycle, mem_rdata goes to the tagged side's rdata output, and that side's rvalid is high for 1 cycle.
- Output relations:
  - cpu_stall = cpu_req & ~cpu_grant.
  - dma_busy = (state==DMA_BURST).
- Requesters hold their address, data and we stable while not granted.
- BURST_LEN==1 is legal: one beat completes the burst immediately and the block never leaves IDLE.

## Timing
- A grant and the memory access occur in the same cycle.
- Writes commit at the clock edge that ends the granted cycle.
- Read latency is 1 cycle from grant to rvalid.
- There is no bubble between owners: a CPU grant may immediately follow the last DMA beat.
- Reset (rst_n low at a clock edge):
  - state←IDLE, counters←0, last_owner←DMA (the CPU wins the first tie), rd_tag←NONE.
  - While rst_n is low, all grants are forced to 0.
  - All outputs read 0, and cpu_stall=0.
- Reset mid-burst discards the burst without a dma_abort pulse. A read return pending at reset is dropped.
- Simultaneous cpu_req and dma_req in IDLE are resolved by last_owner as above.
- A burst always contains exactly BURST_LEN granted beats or ends in abort. It is never preempted by the CPU.

## Structure
- Package dmem_arb_pkg:
  - state_t {IDLE, DMA_BURST}
  - owner_t {OWN_NONE, OWN_CPU, OWN_DMA}
  - default BURST_LEN and MAX_GAP localparams
- No sub-module. It is one flat module: a small FSM, two counters and an output mux (about 150–200 lines).

## Test plan
- After reset, cpu_req=1 with a read at 0x100 (mem holds 0xDEADBEEF): cpu_stall=0, mem_en=1, and the next cycle gives cpu_rvalid=1 with cpu_rdata=0xDEADBEEF.
- dma_req=1 for 16 writes to 0x5000..0x503C while cpu_req=1 from beat 3: cpu_stall=1 for beats 3–16, then a CPU grant in the cycle after beat 16, with dma_grant=0 in that cycle.
- CPU and DMA both continuously requesting from IDLE: the grant sequence is CPU, DMA×16, CPU, DMA×16.
- dma_req dropped after beat 5 for 8 cycles: dma_abort pulses exactly once, on the 8th idle cycle. The CPU is granted in the next cycle, and 5 writes landed.
- rst_n low for 1 cycle during DMA beat 10: all outputs are 0 during reset, dma_abort never pulses, and the state afterwards is IDLE with the CPU winning the first tie.
- DMA read burst with BURST_LEN=16: 16 dma_rvalid pulses, each one cycle after its grant, and cpu_rvalid stays 0 throughout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
// A DMA line is 512 bits moved as 16 words; MAX_GAP bounds how long a stalled burst may hold the port.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE,
        DMA_BURST
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    localparam int DEFAULT_BURST_LEN = 16;
    localparam int DEFAULT_MAX_GAP   = 8;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, DMA and memory-macro signals around the data-memory port arbiter.
// The slave side is the arbiter; the master side is everything around it.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_grant;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_rvalid;
    logic                  dma_busy;
    logic                  dma_abort;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        output dma_grant, dma_rdata, dma_rvalid, dma_busy, dma_abort,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        input  dma_grant, dma_rdata, dma_rvalid, dma_busy, dma_abort,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between CPU single accesses and atomic DMA line bursts,
// alternating round-robin between them and steering one-cycle-latency read data back to the reader.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int MAX_GAP    = DEFAULT_MAX_GAP
) (
    input  logic clk,
    input  logic rst_n,
    dmem_port_arbiter_if.slave bus
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int GAP_W  = $clog2(MAX_GAP + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(MAX_GAP - 1);

    state_t             state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    owner_t             last_owner;
    owner_t             rd_tag;

    logic cpu_grant;
    logic dma_grant;
    logic burst_done;
    logic abort_now;
    logic cpu_rvalid;
    logic dma_rvalid;

    // Inside a burst the DMA owns the port outright; in IDLE a tie goes to whoever did not go last.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (rst_n) begin
            if (state == IDLE) begin
                dma_grant = bus.dma_req && (!bus.cpu_req || last_owner == OWN_CPU);
                cpu_grant = bus.cpu_req && !dma_grant;
            end else begin
                dma_grant = bus.dma_req;
            end
        end
    end

    assign burst_done = dma_grant && ((state == IDLE) ? (BURST_LEN == 1) : (beat_cnt == LAST_BEAT));
    assign abort_now  = rst_n && (state == DMA_BURST) && !bus.dma_req && (gap_cnt == LAST_GAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            last_owner <= OWN_DMA;
            rd_tag     <= OWN_NONE;
        end else begin
            rd_tag <= OWN_NONE;
            if (cpu_grant && !bus.cpu_we) rd_tag <= OWN_CPU;
            if (dma_grant && !bus.dma_we) rd_tag <= OWN_DMA;

            case (state)
                IDLE: begin
                    if (dma_grant) begin
                        if (burst_done) begin
                            last_owner <= OWN_DMA;
                            beat_cnt   <= '0;
                        end else begin
                            state    <= DMA_BURST;
                            beat_cnt <= BEAT_W'(1);
                            gap_cnt  <= '0;
                        end
                    end else if (cpu_grant) begin
                        last_owner <= OWN_CPU;
                    end
                end
                DMA_BURST: begin
                    if (dma_grant) begin
                        gap_cnt <= '0;
                        if (burst_done) begin
                            state      <= IDLE;
                            last_owner <= OWN_DMA;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else if (abort_now) begin
                        // A stalled DMA gives the port up; it counts as the DMA's turn for fairness.
                        state      <= IDLE;
                        last_owner <= OWN_DMA;
                        beat_cnt   <= '0;
                        gap_cnt    <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_en    = cpu_grant | dma_grant;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata = {DATA_WIDTH{1'b0}};
        if (dma_grant) begin
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (cpu_grant) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    assign cpu_rvalid = rst_n && (rd_tag == OWN_CPU);
    assign dma_rvalid = rst_n && (rd_tag == OWN_DMA);

    assign bus.cpu_stall  = rst_n && bus.cpu_req && !cpu_grant;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};

    assign bus.dma_grant  = dma_grant;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.dma_rdata  = dma_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.dma_busy   = rst_n && (state == DMA_BURST);
    assign bus.dma_abort  = abort_now;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: hand-derived grant sequences per cycle, plus a read-return
// scoreboard fed from a reference memory image and a behavioural one-cycle-latency memory macro.
module tb_dmem_port_arbiter;

    typedef struct {
        logic        cpu_rv;
        logic        dma_rv;
        logic [31:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    rd_exp_t     sb_q[$];
    logic [31:0] mem_model [0:16383];
    logic [31:0] ref_mem   [0:16383];

    dmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BURST_LEN (16),
        .MAX_GAP   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory macro: writes commit at the edge ending the grant cycle, reads return one cycle later.
    initial begin
        for (int i = 0; i < 16384; i++) mem_model[i] = 32'h0;
        mem_model[14'h0040] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) mem_model[14'h1C00 + 14'(i)] = 32'h5A5A0000 | 32'(i);
        bus.mem_rdata <= 32'h0;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) mem_model[bus.mem_addr[15:2]] = bus.mem_wdata;
                else            bus.mem_rdata <= mem_model[bus.mem_addr[15:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                                 input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dma_req   = dr;
        bus.dma_we    = dw;
        bus.dma_addr  = da;
        bus.dma_wdata = dd;
    endtask

    // One ordinary cycle: expected grants/status are supplied by the caller, read returns come from the queue.
    task automatic runCycle(input logic exp_cg, input logic exp_dg, input logic exp_busy, input logic exp_abort);
        rd_exp_t due;
        rd_exp_t nxt;
        #1;
        checkOutput("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~exp_cg));
        checkOutput("dma_grant", 32'(bus.dma_grant), 32'(exp_dg));
        checkOutput("mem_en",    32'(bus.mem_en),    32'(exp_cg | exp_dg));
        checkOutput("dma_busy",  32'(bus.dma_busy),  32'(exp_busy));
        checkOutput("dma_abort", 32'(bus.dma_abort), 32'(exp_abort));
        if (exp_cg) begin
            checkOutput("mem_addr_cpu", bus.mem_addr, bus.cpu_addr);
            checkOutput("mem_we_cpu",   32'(bus.mem_we), 32'(bus.cpu_we));
            if (bus.cpu_we) checkOutput("mem_wdata_cpu", bus.mem_wdata, bus.cpu_wdata);
        end
        if (exp_dg) begin
            checkOutput("mem_addr_dma", bus.mem_addr, bus.dma_addr);
            checkOutput("mem_we_dma",   32'(bus.mem_we), 32'(bus.dma_we));
            if (bus.dma_we) checkOutput("mem_wdata_dma", bus.mem_wdata, bus.dma_wdata);
        end

        due.cpu_rv = 1'b0;
        due.dma_rv = 1'b0;
        due.data   = 32'h0;
        if (sb_q.size() > 0) due = sb_q.pop_front();
        checkOutput("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(due.cpu_rv));
        checkOutput("dma_rvalid", 32'(bus.dma_rvalid), 32'(due.dma_rv));
        if (due.cpu_rv) checkOutput("cpu_rdata", bus.cpu_rdata, due.data);
        if (due.dma_rv) checkOutput("dma_rdata", bus.dma_rdata, due.data);

        nxt.cpu_rv = exp_cg && !bus.cpu_we;
        nxt.dma_rv = exp_dg && !bus.dma_we;
        nxt.data   = exp_cg ? ref_mem[bus.cpu_addr[15:2]] : ref_mem[bus.dma_addr[15:2]];
        if (exp_cg && bus.cpu_we) ref_mem[bus.cpu_addr[15:2]] = bus.cpu_wdata;
        if (exp_dg && bus.dma_we) ref_mem[bus.dma_addr[15:2]] = bus.dma_wdata;
        sb_q.push_back(nxt);
        @(negedge clk);
    endtask

    // A cycle with rst_n low: every output must read zero and any pending read is forgotten.
    task automatic resetCycle();
        #1;
        checkOutput("rst_cpu_stall",  32'(bus.cpu_stall),  32'h0);
        checkOutput("rst_dma_grant",  32'(bus.dma_grant),  32'h0);
        checkOutput("rst_mem_en",     32'(bus.mem_en),     32'h0);
        checkOutput("rst_mem_we",     32'(bus.mem_we),     32'h0);
        checkOutput("rst_mem_addr",   bus.mem_addr,        32'h0);
        checkOutput("rst_mem_wdata",  bus.mem_wdata,       32'h0);
        checkOutput("rst_dma_busy",   32'(bus.dma_busy),   32'h0);
        checkOutput("rst_dma_abort",  32'(bus.dma_abort),  32'h0);
        checkOutput("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        checkOutput("rst_cpu_rdata",  bus.cpu_rdata,       32'h0);
        checkOutput("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
        checkOutput("rst_dma_rdata",  bus.dma_rdata,       32'h0);
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
        ref_mem[14'h0040] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) ref_mem[14'h1C00 + 14'(i)] = 32'h5A5A0000 | 32'(i);

        // Reset with both sides requesting: grants must be held off.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h5000, 32'h0);
        repeat (2) @(negedge clk);
        resetCycle();
        rst_n = 1'b1;

        $display("[TB] CPU read after reset");
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        runCycle(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] DMA write burst with CPU stalled from beat 3");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i >= 2, 1'b1, 32'h200, 32'hC0DE0001,
                          1'b1, 1'b1, 32'h5000 + 32'(i * 4), 32'hA0000000 + 32'(i));
            runCycle(1'b0, 1'b1, i > 0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'h200, 32'hC0DE0001, 1'b1, 1'b1, 32'h5040, 32'hA0000010);
        runCycle(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dma_wr_last_word", mem_model[14'h140F], 32'hA000000F);
        checkOutput("cpu_wr_word",      mem_model[14'h0080], 32'hC0DE0001);

        $display("[TB] DMA stalls after beat 5 until abort");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0,
                          1'b1, 1'b1, 32'h6000 + 32'(i * 4), 32'hB0000000 + 32'(i));
            runCycle(1'b0, 1'b1, i > 0, 1'b0);
        end
        for (int g = 1; g <= 8; g++) begin
            applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            runCycle(1'b0, 1'b0, 1'b1, g == 8);
        end
        for (int i = 0; i < 5; i++)
            checkOutput("abort_landed", mem_model[14'h1800 + 14'(i)], 32'hB0000000 + 32'(i));
        checkOutput("abort_not_landed", mem_model[14'h1805], 32'h0);

        $display("[TB] Both sides requesting continuously");
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h8000, 32'hC0000000);
            runCycle(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 16; i++) begin
                applyStimulus(1'b1, 1'b0, 32'h100, 32'h0,
                              1'b1, 1'b1, 32'h8000 + 32'(i * 4), 32'hC0000000 + 32'(r * 256 + i));
                runCycle(1'b0, 1'b1, i > 0, 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rr_second_burst", mem_model[14'h200F], 32'hC000010F);

        $display("[TB] Reset during DMA read beat 10");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h7000 + 32'(i * 4), 32'h0);
            runCycle(1'b0, 1'b1, i > 0, 1'b0);
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h7024, 32'h0);
        resetCycle();
        rst_n = 1'b1;
        runCycle(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] Full DMA read burst");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h7000 + 32'(i * 4), 32'h0);
            runCycle(1'b0, 1'b1, i > 0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);
        runCycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
